// File: rtl/game_pkg.sv
// Shared definitions for the memory-game blocks (sequence player, input matcher).
// State encoding, step width and lamp indices live here so both sides agree.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int STEP_W = 2;

  localparam logic [STEP_W-1:0] LAMP_RED    = 2'd0;
  localparam logic [STEP_W-1:0] LAMP_GREEN  = 2'd1;
  localparam logic [STEP_W-1:0] LAMP_BLUE   = 2'd2;
  localparam logic [STEP_W-1:0] LAMP_YELLOW = 2'd3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/random_sequence_player_step_timer.sv
// Shared step/gap up-counter: restarts on clear or on reaching its terminal count.
// i_sel_b picks which of the two limits defines the terminal count this cycle.
module step_timer #(
  parameter int WIDTH   = 3,
  parameter int LIMIT_A = 4,
  parameter int LIMIT_B = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_sel_b,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] TC_A = WIDTH'(LIMIT_A - 1);
  localparam logic [WIDTH-1:0] TC_B = WIDTH'(LIMIT_B - 1);

  logic [WIDTH-1:0] r_cnt;

  assign o_tc = (r_cnt == (i_sel_b ? TC_B : TC_A));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_cnt <= '0;
    else if (i_clr || o_tc) r_cnt <= '0;
    else                    r_cnt <= r_cnt + WIDTH'(1);
  end

endmodule

// File: rtl/random_sequence_player.sv
// Stores a growing sequence of random lamp indices and replays it as timed
// on/off steps; all outputs come from registers or the state register.
module random_sequence_player
  import game_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 6_250_000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [2:0]                 i_rand_in,
  input  logic                       i_add_step,
  input  logic                       i_clear,
  output logic [STEP_W-1:0]          o_step_out,
  output logic                       o_step_on,
  output logic                       o_busy,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_seq_len,
  output logic                       o_done
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(max2(STEP_CYCLES, GAP_CYCLES) + 1);

  state_t            r_state, w_next;
  logic [STEP_W-1:0] r_mem [DEPTH];
  logic [LW-1:0]     r_len;
  logic [IW-1:0]     r_idx;
  logic [STEP_W-1:0] r_step_out;
  logic              r_done;

  logic          w_tc, w_full, w_last, w_accept, w_tmr_clr, w_sel_gap;
  logic [IW-1:0] w_idx_nxt;
  logic          w_unused;

  // Only the low two bits of the counter select a lamp.
  assign w_unused  = i_rand_in[2];

  assign w_full    = (r_len == LW'(DEPTH));
  assign w_last    = (LW'(r_idx) == r_len - LW'(1));
  assign w_accept  = (r_state == ST_IDLE) && i_add_step && !i_clear;
  assign w_idx_nxt = r_idx + IW'(1);
  assign w_tmr_clr = (r_state == ST_IDLE) || i_clear;
  assign w_sel_gap = (r_state == ST_GAP);

  step_timer #(
    .WIDTH  (TW),
    .LIMIT_A(STEP_CYCLES),
    .LIMIT_B(GAP_CYCLES)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_tmr_clr),
    .i_sel_b(w_sel_gap),
    .o_tc   (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_add_step) w_next = ST_SHOW;
      ST_SHOW: if (w_tc)       w_next = ST_GAP;
      ST_GAP:  if (w_tc)       w_next = w_last ? ST_IDLE : ST_SHOW;
      default:                 w_next = ST_IDLE;
    endcase
    if (i_clear) w_next = ST_IDLE;
  end

  always_comb begin
    o_busy    = (r_state != ST_IDLE);
    o_step_on = (r_state == ST_SHOW);
  end

  assign o_step_out = r_step_out;
  assign o_done     = r_done;
  assign o_full     = w_full;
  assign o_seq_len  = r_len;

  always_ff @(posedge i_clk) begin
    if (w_accept && !w_full) r_mem[r_len[IW-1:0]] <= i_rand_in[1:0];
  end

  // step_out is loaded on entry to SHOW; the first step of a new sequence
  // bypasses the memory since it is being written on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_step_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_clear) begin
        r_len      <= '0;
        r_idx      <= '0;
        r_step_out <= '0;
      end else if (w_accept) begin
        if (!w_full) r_len <= r_len + LW'(1);
        r_idx      <= '0;
        r_step_out <= (r_len == '0) ? i_rand_in[1:0] : r_mem[0];
      end else if (r_state == ST_GAP && w_tc) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_idx      <= w_idx_nxt;
          r_step_out <= r_mem[w_idx_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_random_sequence_player.sv
// Bench for random_sequence_player: a timeline model (playback position p per
// sequence) checked every cycle, plus directed scenarios with literal expectations.
module tb_random_sequence_player;

  localparam int DEPTH = 4;
  localparam int STEP  = 4;
  localparam int GAP   = 2;
  localparam int PER   = STEP + GAP;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    rand_in = 3'd0;
  logic          add_step = 1'b0;
  logic          clear = 1'b0;
  logic [1:0]    step_out;
  logic          step_on, busy, full, done;
  logic [LW-1:0] seq_len;

  int tests = 0;
  int fails = 0;

  random_sequence_player #(
    .DEPTH(DEPTH), .STEP_CYCLES(STEP), .GAP_CYCLES(GAP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rand_in(rand_in), .i_add_step(add_step),
    .i_clear(clear), .o_step_out(step_out), .o_step_on(step_on), .o_busy(busy),
    .o_full(full), .o_seq_len(seq_len), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: sequence as an array, playback as a cycle position p since start.
  int mlen = 0;
  int mseq [DEPTH];
  int p = 0;
  bit mplay = 0;
  bit mdone = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mlen = 0; mplay = 0; mdone = 0; p = 0;
    end else begin
      mdone = 0;
      if (clear) begin
        mlen = 0; mplay = 0;
      end else if (mplay) begin
        p++;
        if (p == PER * mlen) begin
          mplay = 0; mdone = 1;
        end
      end else if (add_step) begin
        if (mlen < DEPTH) begin
          mseq[mlen] = int'(rand_in) % 4;
          mlen++;
        end
        mplay = 1; p = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, mplay);
      chk("step_on", step_on, (mplay && (p % PER) < STEP));
      chk("done", done, mdone);
      chk("seq_len", seq_len, mlen);
      chk("full", full, (mlen == DEPTH));
      if (mplay) chk("step_out", step_out, mseq[p / PER]);
    end
  end

  int cap[$];

  task automatic run_add(input logic [2:0] r, input bit inj,
                         output int on_c, output int off_c, output int dn);
    int tail;
    bit prev;
    on_c = 0; off_c = 0; dn = 0; tail = -1; prev = 0;
    cap.delete();
    @(negedge clk);
    rand_in = r; add_step = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      add_step = inj && (i == 1 || i == 4);
      rand_in  = 3'd0;
      if (step_on) on_c++;
      if (busy && !step_on) off_c++;
      if (step_on && !prev) cap.push_back(int'(step_out));
      prev = step_on;
      if (done) dn++;
      if (tail > 0) tail--;
      if (done && tail < 0) tail = 3;
      if (tail == 0) break;
    end
    if (dn == 0) chk("done_timeout", 0, 1);
  endtask

  int on_c, off_c, dn;

  initial begin
    #12;
    chk("rst_step_out", step_out, 0);
    chk("rst_step_on", step_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_seq_len", seq_len, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: single step from rand 6 -> lamp 2
    run_add(3'd6, 0, on_c, off_c, dn);
    chk("t1_on", on_c, 4); chk("t1_off", off_c, 2); chk("t1_done", dn, 1);
    chk("t1_ncap", cap.size(), 1); chk("t1_val", cap[0], 2);
    chk("t1_len", seq_len, 1); chk("t1_busy", busy, 0);

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_len", seq_len, 0);

    // 2: grow {1},{1,3},{1,3,0}
    run_add(3'd1, 0, on_c, off_c, dn);
    chk("t2a_on", on_c, 4); chk("t2a_val0", cap[0], 1); chk("t2a_done", dn, 1);
    run_add(3'd7, 0, on_c, off_c, dn);
    chk("t2b_on", on_c, 8); chk("t2b_off", off_c, 4);
    chk("t2b_val0", cap[0], 1); chk("t2b_val1", cap[1], 3); chk("t2b_done", dn, 1);
    run_add(3'd0, 0, on_c, off_c, dn);
    chk("t2c_on", on_c, 12); chk("t2c_off", off_c, 6); chk("t2c_ncap", cap.size(), 3);
    chk("t2c_val2", cap[2], 0); chk("t2c_done", dn, 1); chk("t2c_len", seq_len, 3);

    // 3: fill to DEPTH, then one more add must not write
    run_add(3'd5, 0, on_c, off_c, dn);
    chk("t3a_len", seq_len, 4); chk("t3a_full", full, 1); chk("t3a_val3", cap[3], 1);
    run_add(3'd2, 0, on_c, off_c, dn);
    chk("t3b_len", seq_len, 4); chk("t3b_on", on_c, 16); chk("t3b_done", dn, 1);
    chk("t3b_val0", cap[0], 1); chk("t3b_val1", cap[1], 3);
    chk("t3b_val2", cap[2], 0); chk("t3b_val3", cap[3], 1);

    // 4: add_step during SHOW and GAP is ignored
    run_add(3'd2, 1, on_c, off_c, dn);
    chk("t4_len", seq_len, 4); chk("t4_on", on_c, 16); chk("t4_off", off_c, 8);
    chk("t4_done", dn, 1); chk("t4_val3", cap[3], 1);

    // 5: clear + add_step in 2nd SHOW cycle
    @(negedge clk); rand_in = 3'd2; add_step = 1'b1;
    @(negedge clk); add_step = 1'b0;
    @(negedge clk); clear = 1'b1; add_step = 1'b1;
    @(negedge clk); clear = 1'b0; add_step = 1'b0;
    chk("t5_busy", busy, 0); chk("t5_len", seq_len, 0);
    chk("t5_on", step_on, 0); chk("t5_done", done, 0);
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("t5_nodone", dn, 0);

    // 6: async reset in the middle of GAP
    @(negedge clk); rand_in = 3'd3; add_step = 1'b1;
    @(negedge clk); add_step = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_gap_on", step_on, 0); chk("t6_gap_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_step_out", step_out, 0); chk("t6_on", step_on, 0);
    chk("t6_busy", busy, 0); chk("t6_full", full, 0);
    chk("t6_len", seq_len, 0); chk("t6_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    run_add(3'd4, 0, on_c, off_c, dn);
    chk("t6_newlen", seq_len, 1); chk("t6_ncap", cap.size(), 1);
    chk("t6_val", cap[0], 0); chk("t6_newdone", dn, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
